// File: rtl/pic_priority_core.sv
// pic_priority_core
//   Priority resolver and two-pulse INTA handshake for a PIC-style interrupt
//   controller. Requests are captured into irr (edge or level), resolved in a
//   rotating priority order against the in-service register, and acknowledged
//   through an IDLE/ACK1/ACK2 sequence that presents the channel index.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   irq_in            raw requests, synchronous to clk
//   edge_mode         1 = rising-edge capture, 0 = level capture
//   mask              1 = channel excluded from resolution
//   rotate_en         1 = lowest-priority pointer follows serviced channel
//   auto_eoi          1 = isr bit cleared at end of acknowledge
//   inta_n            acknowledge strobe, active low
//   eoi_valid/_specific/_level   end-of-interrupt command
//   int_out           registered interrupt request to CPU
//   vec_valid/vec_id  one-cycle vector pulse and held channel index
//   irr, isr          request and in-service registers
//
// State table
//   S_IDLE | int_out follows candidate; waiting for first INTA falling edge
//   S_ACK1 | index latched, waiting for inta_n to return high
//   S_ACK2 | waiting for second INTA falling edge to present the vector

module pic_priority_core #(
   parameter int N_IRQ = 8,
   parameter int IDX_W = $clog2(N_IRQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             edge_mode,
   input  logic [N_IRQ-1:0] mask,
   input  logic             rotate_en,
   input  logic             auto_eoi,
   input  logic             inta_n,
   input  logic             eoi_valid,
   input  logic             eoi_specific,
   input  logic [IDX_W-1:0] eoi_level,
   output logic             int_out,
   output logic             vec_valid,
   output logic [IDX_W-1:0] vec_id,
   output logic [N_IRQ-1:0] irr,
   output logic [N_IRQ-1:0] isr
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK1 = 2'd1, S_ACK2 = 2'd2} state_t;

   state_t           r_state;
   logic [N_IRQ-1:0] r_irr, r_isr, r_irq_prev;
   logic [IDX_W-1:0] r_lp, r_idx, r_vec_id;
   logic             r_spur, r_inta_prev, r_int_out, r_vec_valid;

   logic [IDX_W-1:0] w_hp, w_isr_idx, w_cand_idx, w_eoi_idx, w_lp_nxt;
   logic             w_isr_hit, w_cand_hit, w_eoi_hit;
   logic             w_ack_edge, w_ack_take, w_auto_clr;
   logic [N_IRQ-1:0] w_req, w_isr_clr, w_isr_set, w_irr_nxt;

   assign w_ack_edge = r_inta_prev & ~inta_n;
   assign w_req      = r_irr & ~mask;
   assign w_hp       = (r_lp == IDX_W'(N_IRQ - 1)) ? '0 : r_lp + IDX_W'(1);

   // Walk channels from hp upward with wrap. The first isr bit met ends the
   // search for a candidate, so only strictly higher-priority requests win.
   always_comb begin
      logic [IDX_W:0]   pos;
      logic [IDX_W-1:0] idx;
      pos        = '0;
      idx        = '0;
      w_isr_hit  = 1'b0;
      w_isr_idx  = '0;
      w_cand_hit = 1'b0;
      w_cand_idx = '0;
      for (int k = 0; k < N_IRQ; k++) begin
         pos = {1'b0, w_hp} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(N_IRQ))
            pos = pos - (IDX_W+1)'(N_IRQ);
         idx = pos[IDX_W-1:0];
         if (!w_isr_hit && r_isr[idx]) begin
            w_isr_hit = 1'b1;
            w_isr_idx = idx;
         end else if (!w_isr_hit && !w_cand_hit && w_req[idx]) begin
            w_cand_hit = 1'b1;
            w_cand_idx = idx;
         end
      end
   end

   always_comb begin
      w_eoi_hit = 1'b0;
      w_eoi_idx = w_isr_idx;
      if (eoi_valid) begin
         if (eoi_specific) begin
            w_eoi_idx = eoi_level;
            w_eoi_hit = ({1'b0, eoi_level} < (IDX_W+1)'(N_IRQ)) && r_isr[eoi_level];
         end else begin
            w_eoi_hit = w_isr_hit;
         end
      end
   end

   assign w_ack_take = (r_state == S_IDLE) && w_ack_edge && w_cand_hit;
   assign w_auto_clr = (r_state == S_ACK2) && w_ack_edge && auto_eoi && !r_spur;

   // Clears are applied before sets, so a bit cleared and set together ends set.
   always_comb begin
      w_isr_clr = '0;
      w_isr_set = '0;
      w_lp_nxt  = r_lp;
      if (w_eoi_hit)  w_isr_clr[w_eoi_idx]  = 1'b1;
      if (w_auto_clr) w_isr_clr[r_idx]      = 1'b1;
      if (w_ack_take) w_isr_set[w_cand_idx] = 1'b1;
      if (rotate_en) begin
         if (w_auto_clr)     w_lp_nxt = r_idx;
         else if (w_eoi_hit) w_lp_nxt = w_eoi_idx;
      end
      w_irr_nxt = edge_mode ? ((r_irr & ~w_isr_set) | (irq_in & ~r_irq_prev))
                            : (irq_in & ~w_isr_set);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_irr       <= '0;
         r_isr       <= '0;
         r_irq_prev  <= '0;
         r_lp        <= IDX_W'(N_IRQ - 1);
         r_idx       <= '0;
         r_spur      <= 1'b0;
         r_inta_prev <= 1'b1;
         r_int_out   <= 1'b0;
         r_vec_valid <= 1'b0;
         r_vec_id    <= '0;
      end else begin
         r_irq_prev  <= irq_in;
         r_inta_prev <= inta_n;
         r_irr       <= w_irr_nxt;
         r_isr       <= (r_isr & ~w_isr_clr) | w_isr_set;
         r_lp        <= w_lp_nxt;
         r_int_out   <= 1'b0;
         r_vec_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_ack_edge) begin
                  // No candidate: spurious acknowledge reports the last channel.
                  r_idx   <= w_cand_hit ? w_cand_idx : IDX_W'(N_IRQ - 1);
                  r_spur  <= !w_cand_hit;
                  r_state <= S_ACK1;
               end else begin
                  r_int_out <= w_cand_hit;
               end
            end
            S_ACK1: begin
               if (inta_n) r_state <= S_ACK2;
            end
            S_ACK2: begin
               if (w_ack_edge) begin
                  r_vec_valid <= 1'b1;
                  r_vec_id    <= r_idx;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign int_out   = r_int_out;
   assign vec_valid = r_vec_valid;
   assign vec_id    = r_vec_id;
   assign irr       = r_irr;
   assign isr       = r_isr;

endmodule

// File: doc/pic_priority_core.md
PIC_PRIORITY_CORE -- requirements
Module: pic_priority_core

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of request channels (legal 2..16).
REQ-002 SHALL have parameter IDX_W, default $clog2(N_IRQ), channel index width.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port irq_in  in  N_IRQ  raw interrupt requests, synchronous to clk.
REQ-006 SHALL have port edge_mode  in  1  1 = rising-edge triggered, 0 = level triggered.
REQ-007 SHALL have port mask  in  N_IRQ  1 = channel masked.
REQ-008 SHALL have port rotate_en  in  1  1 = automatic rotation, 0 = fully nested fixed order.
REQ-009 SHALL have port auto_eoi  in  1  1 = ISR bit cleared at end of acknowledge.
REQ-010 SHALL have port inta_n  in  1  interrupt acknowledge, active low, sampled on clk.
REQ-011 SHALL have port eoi_valid  in  1  one-cycle end-of-interrupt command strobe.
REQ-012 SHALL have port eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
REQ-013 SHALL have port eoi_level  in  IDX_W  channel index for specific EOI.
REQ-014 SHALL have port int_out  out  1  registered interrupt request to CPU.
REQ-015 SHALL have port vec_valid  out  1  one-cycle pulse, vec_id valid.
REQ-016 SHALL have port vec_id  out  IDX_W  acknowledged channel index.
REQ-017 SHALL have ports irr, isr  out  N_IRQ  request and in-service registers.

Function
REQ-018 Edge mode SHALL set irr[i] on cycle after irq_in[i] rises (0->1 versus registered previous value); bit held until acknowledged.
REQ-019 Level mode SHALL load irr[i] = irq_in[i] every cycle, except the bit being acknowledged that cycle is cleared.
REQ-020 Priority order SHALL start at index hp = (lp+1) mod N_IRQ and ascend with wrap; lp is lowest-priority pointer, reset N_IRQ-1 (index 0 highest).
REQ-021 lp SHALL change only when rotate_en=1: set to the index of each ISR bit cleared by EOI or auto-EOI.
REQ-022 Candidate SHALL be first set bit of irr & ~mask in priority order that is strictly higher priority than highest set isr bit; none if no such bit.
REQ-023 int_out SHALL be registered: 1 in cycle after a candidate exists while FSM is IDLE, else 0.
REQ-024 FSM states SHALL be IDLE, ACK1, ACK2; ack edge = inta_n 1 previous cycle, 0 current cycle.
REQ-025 IDLE + ack edge: candidate index latched, its isr bit set and irr bit cleared, int_out deasserted; -> ACK1.
REQ-026 IDLE + ack edge with no candidate (spurious): latched index = N_IRQ-1, isr/irr unchanged; -> ACK1.
REQ-027 ACK1 + inta_n high -> ACK2; ACK2 + ack edge: vec_valid=1 one cycle, vec_id = latched index; -> IDLE.
REQ-028 At ACK2 completion with auto_eoi=1 and non-spurious, the latched isr bit SHALL clear same edge and lp updated per REQ-021.
REQ-029 Non-specific EOI SHALL clear highest-priority set isr bit; specific EOI SHALL clear isr[eoi_level]; EOI with isr empty, target bit clear or eoi_level >= N_IRQ: no effect.
REQ-030 EOI and ack-set in same cycle: clear applied first, set second; a bit both set and cleared ends set.
REQ-031 mask changes SHALL affect candidate same cycle; masking does not clear irr or isr.
REQ-032 vec_id SHALL hold last value between pulses.

Reset
REQ-033 rst_n low SHALL asynchronously force irr=0, isr=0, previous-irq register=0, lp=N_IRQ-1, FSM=IDLE, int_out=0, vec_valid=0, vec_id=0, inta_n history=1.
REQ-034 Reset mid-handshake SHALL abandon the acknowledge with no vec_valid pulse.

Verification
REQ-035 N=8, fixed, edge: raise irq_in[3] and [5] -> int_out=1; two INTA pulses -> vec_id=3, isr=0x08, irr=0x20.
REQ-036 isr=0x08, irr=0x20 -> int_out=0; raise irq_in[1] -> int_out=1, ack gives vec_id=1, isr=0x0A.
REQ-037 rotate_en=1, non-specific EOI with isr=0x04 -> isr=0, lp=2; pending 0 and 4 -> next vec_id=4.
REQ-038 auto_eoi=1, ack irq 6 -> vec_valid with vec_id=6, isr=0 after pulse.
REQ-039 Spurious: irq pulse removed (level mode) before first INTA -> vec_id=7, isr unchanged.
REQ-040 N_IRQ=16: specific EOI eoi_level=12 with isr=0x1000 -> isr=0; reset during ACK1 -> FSM IDLE, no vec_valid.
